router_fsm: RTL and testbench
=============================

# router_fsm

Packet-sequencing controller for the 1x3 router input path. Decodes the header address of each incoming packet and steps the input register and destination FIFO write path through header, payload and parity loading. Stalls on a full destination FIFO and waits for a busy destination to drain. Sits between the input port and the router's register/synchronizer blocks, which gate its write strobe into one of the three 16-deep FIFOs.

## Interface
- No parameters; FIFO count fixed at 3, address width 2.
- clock  in  1  system clock; all state changes on rising edge
- resetn  in  1  reset resetn, synchronous, active-low; clock clock
- pkt_valid  in  1  high while header/payload bytes are presented; low on the parity byte
- data_in  in  2  header address field (header byte bits [1:0]); 3 is invalid
- fifo_full  in  1  full flag of the currently selected FIFO (muxed externally)
- fifo_empty_0/1/2  in  1 each  empty flags of the three FIFOs
- soft_reset_0/1/2  in  1 each  per-FIFO timeout soft reset from synchronizer
- parity_done  in  1  register block has captured the parity byte
- low_pkt_valid  in  1  pkt_valid fell while the FSM was stalled on full
- detect_add  out  1  high in DECODE_ADDRESS
- lfd_state  out  1  high in LOAD_FIRST_DATA (marks header write)
- ld_state  out  1  high in LOAD_DATA
- laf_state  out  1  high in LOAD_AFTER_FULL
- full_state  out  1  high in FIFO_FULL_STATE
- rst_int_reg  out  1  high in CHECK_PARITY_ERROR
- write_enb_reg  out  1  FIFO write request
- busy  out  1  back-pressure to source; source holds data while high

## Operation
- Moore FSM; outputs decoded from state register only. 3-bit state register; 2-bit addr_q latched.
- DECODE_ADDRESS: if pkt_valid and data_in=k (k<3): fifo_empty_k -> LOAD_FIRST_DATA, else -> WAIT_TILL_EMPTY; addr_q<=k. data_in=3 or !pkt_valid: stay, addr_q unchanged.
- WAIT_TILL_EMPTY: busy=1. fifo_empty_[addr_q] -> LOAD_FIRST_DATA, else stay.
- LOAD_FIRST_DATA: busy=1, write_enb_reg=1, lfd_state=1. Unconditional -> LOAD_DATA.
- LOAD_DATA: busy=0, write_enb_reg=1. fifo_full -> FIFO_FULL_STATE (priority); else !pkt_valid -> LOAD_PARITY; else stay.
- FIFO_FULL_STATE: busy=1, write_enb_reg=0. !fifo_full -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL: busy=1, write_enb_reg=1. parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
- LOAD_PARITY: busy=1, write_enb_reg=1. Unconditional -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: busy=1, rst_int_reg=1. fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- Soft reset: soft_reset_[addr_q] high in any state except DECODE_ADDRESS forces DECODE_ADDRESS next cycle; overrides all other transitions. soft_reset for non-selected FIFOs ignored.
- All unlisted outputs 0 in each state. Illegal state encodings -> DECODE_ADDRESS.

## Timing
- Reset: state=DECODE_ADDRESS, addr_q=0; outputs detect_add=1, all others 0, in the cycle after resetn sampled low.
- resetn low mid-packet aborts immediately; no partial-packet cleanup in this block.
- Header accepted the cycle detect_add=1 and pkt_valid=1; header written one cycle later (LOAD_FIRST_DATA).
- Minimum packet (empty FIFO, never full): DECODE, LFD, LD x N, LP, CPE = N+4 cycles, back-to-back capable.
- busy rises combinationally with the state; source samples it at the same edge as data.

## Structure
- Shared package router_pkg: state encoding constants (DECODE_ADDRESS=0 ... CHECK_PARITY_ERROR=7), ADDR_INVALID=2'd3, NUM_FIFOS=3.
- No sub-module; empty/soft-reset selection by addr_q is an inline mux.

## Test plan
- Reset then pkt_valid=1, data_in=1, fifo_empty_1=1 -> LFD next cycle, lfd_state=1, write_enb_reg=1, busy=1; then LOAD_DATA with busy=0.
- data_in=2, fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY, busy=1, write_enb_reg=0 for 5 cycles; empty rises -> LFD.
- 4-byte payload, fifo_full pulsed 3 cycles in LOAD_DATA -> FIFO_FULL_STATE 3 cycles, full_state=1; then LOAD_AFTER_FULL; parity_done=0, low_pkt_valid=0 -> LOAD_DATA.
- pkt_valid drops in LOAD_DATA -> LOAD_PARITY, then CHECK_PARITY_ERROR with rst_int_reg=1, then DECODE_ADDRESS.
- addr_q=0, soft_reset_0 in LOAD_DATA -> DECODE_ADDRESS next cycle; soft_reset_1 at same point -> no effect.
- data_in=3 with pkt_valid=1 -> remains in DECODE_ADDRESS, detect_add=1, write_enb_reg=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router packet-sequencing controller:
// state encodings, address constants and the decoded control-output bundle.
package router_pkg;

  localparam int unsigned NUM_FIFOS = 3;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned STATE_W   = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  localparam logic [STATE_W-1:0] DECODE_ADDRESS     = 3'd0;
  localparam logic [STATE_W-1:0] LOAD_FIRST_DATA    = 3'd1;
  localparam logic [STATE_W-1:0] LOAD_DATA          = 3'd2;
  localparam logic [STATE_W-1:0] LOAD_PARITY        = 3'd3;
  localparam logic [STATE_W-1:0] FIFO_FULL_STATE    = 3'd4;
  localparam logic [STATE_W-1:0] LOAD_AFTER_FULL    = 3'd5;
  localparam logic [STATE_W-1:0] WAIT_TILL_EMPTY    = 3'd6;
  localparam logic [STATE_W-1:0] CHECK_PARITY_ERROR = 3'd7;

  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_reg;
    logic write_enb_reg;
    logic busy;
  } fsm_out_t;

  // Moore output decode for a given state.
  function automatic fsm_out_t decode_state(input logic [STATE_W-1:0] s);
    fsm_out_t o;
    o = '0;
    case (s)
      DECODE_ADDRESS:     o.detect_add = 1'b1;
      LOAD_FIRST_DATA: begin
        o.lfd_state     = 1'b1;
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      LOAD_DATA: begin
        o.ld_state      = 1'b1;
        o.write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      FIFO_FULL_STATE: begin
        o.full_state    = 1'b1;
        o.busy          = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        o.laf_state     = 1'b1;
        o.write_enb_reg = 1'b1;
        o.busy          = 1'b1;
      end
      WAIT_TILL_EMPTY:    o.busy = 1'b1;
      CHECK_PARITY_ERROR: begin
        o.rst_int_reg   = 1'b1;
        o.busy          = 1'b1;
      end
      default:            o.detect_add = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router input path: decodes the
// header address and steps header/payload/parity loading into the selected FIFO.
module router_fsm
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy
);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  fsm_out_t             out_q, out_d;
  logic [NUM_FIFOS-1:0] empty_vec_c;
  logic [NUM_FIFOS-1:0] soft_rst_vec_c;
  logic                 hdr_empty_c;
  logic                 sel_empty_c;
  logic                 sel_soft_rst_c;

  assign empty_vec_c    = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_rst_vec_c = {soft_reset_2, soft_reset_1, soft_reset_0};

  // Empty/soft-reset selection: by incoming header address and by latched address.
  always_comb begin
    hdr_empty_c    = 1'b0;
    sel_empty_c    = 1'b0;
    sel_soft_rst_c = 1'b0;
    case (data_in)
      2'd0:    hdr_empty_c = empty_vec_c[0];
      2'd1:    hdr_empty_c = empty_vec_c[1];
      2'd2:    hdr_empty_c = empty_vec_c[2];
      default: hdr_empty_c = 1'b0;
    endcase
    case (addr_q)
      2'd0: begin
        sel_empty_c    = empty_vec_c[0];
        sel_soft_rst_c = soft_rst_vec_c[0];
      end
      2'd1: begin
        sel_empty_c    = empty_vec_c[1];
        sel_soft_rst_c = soft_rst_vec_c[1];
      end
      2'd2: begin
        sel_empty_c    = empty_vec_c[2];
        sel_soft_rst_c = soft_rst_vec_c[2];
      end
      default: begin
        sel_empty_c    = 1'b0;
        sel_soft_rst_c = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && (data_in != ADDR_INVALID)) begin
          addr_d  = data_in;
          state_d = hdr_empty_c ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (sel_empty_c) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            state_d = DECODE_ADDRESS;
    endcase
    // Timeout soft reset of the selected FIFO overrides every transition.
    if ((state_q != DECODE_ADDRESS) && sel_soft_rst_c) state_d = DECODE_ADDRESS;
    out_d = decode_state(state_d);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
      out_q   <= decode_state(DECODE_ADDRESS);
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
    end
  end

  assign detect_add    = out_q.detect_add;
  assign lfd_state     = out_q.lfd_state;
  assign ld_state      = out_q.ld_state;
  assign laf_state     = out_q.laf_state;
  assign full_state    = out_q.full_state;
  assign rst_int_reg   = out_q.rst_int_reg;
  assign write_enb_reg = out_q.write_enb_reg;
  assign busy          = out_q.busy;

endmodule

// File: tb/tb_router_fsm.sv
// Directed-vector bench for router_fsm: each step applies inputs, clocks once
// and compares the full output bundle against a hand-computed per-state value.
module tb_router_fsm;

  // {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy}
  localparam logic [7:0] EXP_DA  = 8'h80;
  localparam logic [7:0] EXP_LFD = 8'h43;
  localparam logic [7:0] EXP_LD  = 8'h22;
  localparam logic [7:0] EXP_WTE = 8'h01;
  localparam logic [7:0] EXP_FFS = 8'h09;
  localparam logic [7:0] EXP_LAF = 8'h13;
  localparam logic [7:0] EXP_LP  = 8'h03;
  localparam logic [7:0] EXP_CPE = 8'h05;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, write_enb_reg, busy;

  int n_vec  = 0;
  int n_miss = 0;

  router_fsm dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Clock once with the current inputs, then compare the output bundle.
  task automatic step(input string tag, input logic [7:0] exp);
    @(posedge clock);
    #1;
    chk(tag, {detect_add, lfd_state, ld_state, laf_state,
              full_state, rst_int_reg, write_enb_reg, busy}, exp);
  endtask

  initial begin
    resetn        = 1'b0;
    pkt_valid     = 1'b0;
    data_in       = 2'd0;
    fifo_full     = 1'b0;
    fifo_empty_0  = 1'b1;
    fifo_empty_1  = 1'b1;
    fifo_empty_2  = 1'b1;
    soft_reset_0  = 1'b0;
    soft_reset_1  = 1'b0;
    soft_reset_2  = 1'b0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;

    step("reset", EXP_DA);
    resetn = 1'b1;
    step("idle", EXP_DA);

    // Packet to FIFO 1, empty: header, one payload, parity, check.
    pkt_valid = 1'b1; data_in = 2'd1;
    step("p1_lfd", EXP_LFD);
    step("p1_ld", EXP_LD);
    pkt_valid = 1'b0;
    step("p1_lp", EXP_LP);
    step("p1_cpe", EXP_CPE);
    step("p1_da", EXP_DA);

    // Invalid address is ignored.
    pkt_valid = 1'b1; data_in = 2'd3;
    step("inv_a", EXP_DA);
    step("inv_b", EXP_DA);

    // FIFO 2 busy for 5 cycles.
    data_in = 2'd2; fifo_empty_2 = 1'b0;
    for (int i = 0; i < 5; i++) step($sformatf("wte_%0d", i), EXP_WTE);
    fifo_empty_2 = 1'b1; data_in = 2'd0;
    step("wte_lfd", EXP_LFD);
    step("p2_ld0", EXP_LD);
    step("p2_ld1", EXP_LD);

    // Full for 3 cycles mid-payload, resume into LOAD_DATA.
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("ffs_%0d", i), EXP_FFS);
    fifo_full = 1'b0;
    step("laf", EXP_LAF);
    step("laf_ld", EXP_LD);

    // Full again; this time low_pkt_valid sends LAF to LOAD_PARITY.
    fifo_full = 1'b1;
    step("ffs2", EXP_FFS);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    step("laf2", EXP_LAF);
    pkt_valid = 1'b0;
    step("laf2_lp", EXP_LP);
    low_pkt_valid = 1'b0; fifo_full = 1'b1;
    step("cpe2", EXP_CPE);
    step("cpe2_ffs", EXP_FFS);
    fifo_full = 1'b0; parity_done = 1'b1;
    step("laf3", EXP_LAF);
    step("laf3_da", EXP_DA);
    parity_done = 1'b0;

    // Soft reset of the selected FIFO (0); soft reset in DECODE_ADDRESS ignored.
    pkt_valid = 1'b1; data_in = 2'd0; soft_reset_0 = 1'b1;
    step("sr_lfd", EXP_LFD);
    soft_reset_0 = 1'b0;
    step("sr_ld", EXP_LD);
    soft_reset_1 = 1'b1;
    step("sr_other", EXP_LD);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    step("sr_sel", EXP_DA);
    soft_reset_0 = 1'b0;

    // Header to a non-empty FIFO 1 then soft reset from WAIT_TILL_EMPTY.
    data_in = 2'd1; fifo_empty_1 = 1'b0;
    step("sr_wte", EXP_WTE);
    soft_reset_2 = 1'b1;
    step("sr_wte_other", EXP_WTE);
    soft_reset_2 = 1'b0; soft_reset_1 = 1'b1;
    step("sr_wte_sel", EXP_DA);
    soft_reset_1 = 1'b0; fifo_empty_1 = 1'b1;

    // Synchronous reset aborts a packet mid-payload.
    step("rst_lfd", EXP_LFD);
    step("rst_ld", EXP_LD);
    resetn = 1'b0;
    step("rst_mid", EXP_DA);
    resetn = 1'b1; pkt_valid = 1'b0;
    step("rst_idle", EXP_DA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
